raster_stepper: RTL and testbench

Parametrised 2D position generator that keeps a registered (x, y) coordinate inside a WIDTH×HEIGHT-bit field. It has two modes: step mode applies signed (dx, dy) commands, and raster mode auto-scans the field. Each position is delivered over a valid/ready output handshake. The block is the sequential successor of the combinational offset submodule and is instantiated by display and sprite-walk tops with per-instance limits.

---
 rtl/raster_stepper_if.sv | 31 +++
 rtl/raster_stepper.sv | 183 ++++++++++++++++++
 tb/tb_raster_stepper.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/raster_stepper_if.sv
// raster_stepper_if: step-command and position-output channels of raster_stepper.
//   step_valid/step_ready/step_dx/step_dy : signed (dx, dy) command handshake
//   pos_valid/pos_ready/pos_x/pos_y        : position output handshake
//   wrap_x/wrap_y                          : last update wrapped or saturated an axis
// The master modport is the side that issues steps and consumes positions;
// the slave modport is the position generator itself.
interface raster_stepper_if #(
  parameter int WIDTH  = 10,
  parameter int HEIGHT = 11
);
  logic              step_valid;
  logic              step_ready;
  logic [WIDTH-1:0]  step_dx;
  logic [HEIGHT-1:0] step_dy;
  logic              pos_valid;
  logic              pos_ready;
  logic [WIDTH-1:0]  pos_x;
  logic [HEIGHT-1:0] pos_y;
  logic              wrap_x;
  logic              wrap_y;

  modport master (
    output step_valid, step_dx, step_dy, pos_ready,
    input  step_ready, pos_valid, pos_x, pos_y, wrap_x, wrap_y
  );

  modport slave (
    input  step_valid, step_dx, step_dy, pos_ready,
    output step_ready, pos_valid, pos_x, pos_y, wrap_x, wrap_y
  );
endinterface

// File: rtl/raster_stepper.sv
// raster_stepper: registered (x, y) position generator inside an
// X_LIMIT x Y_LIMIT field. Step mode applies signed (dx, dy) commands with
// wrap or saturate at the field edges; raster mode scans the field row by row
// from the origin and pulses done after the last position is taken.
// Ports:
//   clock, rst_n         : rising-edge clock, asynchronous active-low reset
//   start, stop, mode    : start in IDLE (mode sampled), stop abandons ACTIVE
//   origin_x, origin_y   : start position, clamped into the field
//   bus (slave)          : step command and position output handshakes
//   busy                 : block is ACTIVE
//   done                 : one-cycle pulse after the final raster transfer
//   count                : positions accepted downstream since start (saturating)
module raster_stepper #(
  parameter int WIDTH   = 10,
  parameter int HEIGHT  = 11,
  parameter int X_LIMIT = 640,
  parameter int Y_LIMIT = 480,
  parameter int WRAP    = 1
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    mode,
  input  logic [WIDTH-1:0]        origin_x,
  input  logic [HEIGHT-1:0]       origin_y,
  raster_stepper_if.slave         bus,
  output logic                    busy,
  output logic                    done,
  output logic [WIDTH+HEIGHT-1:0] count
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [WIDTH-1:0]         X_MAX   = WIDTH'(X_LIMIT - 1);
  localparam logic [HEIGHT-1:0]        Y_MAX   = HEIGHT'(Y_LIMIT - 1);
  localparam logic signed [WIDTH+1:0]  X_LIM_S = (WIDTH+2)'(X_LIMIT);
  localparam logic signed [HEIGHT+1:0] Y_LIM_S = (HEIGHT+2)'(Y_LIMIT);

  state_t                  state_q;
  logic                    mode_q;
  logic [WIDTH-1:0]        pos_x_q;
  logic [HEIGHT-1:0]       pos_y_q;
  logic                    pos_valid_q;
  logic                    wrap_x_q;
  logic                    wrap_y_q;
  logic                    done_q;
  logic [WIDTH+HEIGHT-1:0] count_q;

  logic                    xfer;
  logic                    step_fire;
  logic                    step_ready;
  logic [WIDTH-1:0]        origin_cx;
  logic [HEIGHT-1:0]       origin_cy;

  // Step-mode next position per axis. The sum carries two extra bits so both
  // the negative and the >= limit cases are representable before correction.
  logic signed [WIDTH+1:0]  sum_x;
  logic signed [HEIGHT+1:0] sum_y;
  logic [WIDTH-1:0]         step_x;
  logic [HEIGHT-1:0]        step_y;
  logic                     step_wrap_x;
  logic                     step_wrap_y;

  // pos_ready -> step_ready is the only combinational path through the block.
  assign step_ready = (state_q == ACTIVE) && !mode_q && (!pos_valid_q || bus.pos_ready);
  assign xfer       = pos_valid_q && bus.pos_ready;
  assign step_fire  = bus.step_valid && step_ready;

  assign origin_cx = (int'(origin_x) >= X_LIMIT) ? X_MAX : origin_x;
  assign origin_cy = (int'(origin_y) >= Y_LIMIT) ? Y_MAX : origin_y;

  // NOTE: combinational blocks use blocking assignments and give every output
  // a default first, so no path can leave a value unassigned (no latch).
  always_comb begin
    sum_x       = $signed({2'b00, pos_x_q}) + $signed({{2{bus.step_dx[WIDTH-1]}}, bus.step_dx});
    step_x      = sum_x[WIDTH-1:0];
    step_wrap_x = 1'b0;
    if (sum_x < 0) begin
      step_wrap_x = 1'b1;
      step_x      = (WRAP != 0) ? WIDTH'(sum_x + X_LIM_S) : '0;
    end else if (sum_x >= X_LIM_S) begin
      step_wrap_x = 1'b1;
      step_x      = (WRAP != 0) ? WIDTH'(sum_x - X_LIM_S) : X_MAX;
    end
  end

  always_comb begin
    sum_y       = $signed({2'b00, pos_y_q}) + $signed({{2{bus.step_dy[HEIGHT-1]}}, bus.step_dy});
    step_y      = sum_y[HEIGHT-1:0];
    step_wrap_y = 1'b0;
    if (sum_y < 0) begin
      step_wrap_y = 1'b1;
      step_y      = (WRAP != 0) ? HEIGHT'(sum_y + Y_LIM_S) : '0;
    end else if (sum_y >= Y_LIM_S) begin
      step_wrap_y = 1'b1;
      step_y      = (WRAP != 0) ? HEIGHT'(sum_y - Y_LIM_S) : Y_MAX;
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      pos_x_q     <= '0;
      pos_y_q     <= '0;
      pos_valid_q <= 1'b0;
      wrap_x_q    <= 1'b0;
      wrap_y_q    <= 1'b0;
      done_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= ACTIVE;
            mode_q      <= mode;
            pos_x_q     <= origin_cx;
            pos_y_q     <= origin_cy;
            pos_valid_q <= mode;
            wrap_x_q    <= 1'b0;
            wrap_y_q    <= 1'b0;
            count_q     <= '0;
          end
        end

        ACTIVE: begin
          if (stop) begin
            // Abort takes priority over any step or transfer this cycle.
            state_q     <= IDLE;
            pos_valid_q <= 1'b0;
          end else begin
            if (xfer && (count_q != '1)) begin
              count_q <= count_q + 1'b1;
            end
            if (!mode_q) begin
              if (step_fire) begin
                pos_x_q     <= step_x;
                pos_y_q     <= step_y;
                wrap_x_q    <= step_wrap_x;
                wrap_y_q    <= step_wrap_y;
                pos_valid_q <= 1'b1;
              end else if (xfer) begin
                pos_valid_q <= 1'b0;
              end
            end else if (xfer) begin
              if (pos_x_q == X_MAX && pos_y_q == Y_MAX) begin
                done_q      <= 1'b1;
                pos_valid_q <= 1'b0;
                state_q     <= IDLE;
              end else if (pos_x_q == X_MAX) begin
                pos_x_q  <= '0;
                pos_y_q  <= pos_y_q + 1'b1;
                wrap_x_q <= 1'b1;
                wrap_y_q <= 1'b0;
              end else begin
                pos_x_q  <= pos_x_q + 1'b1;
                wrap_x_q <= 1'b0;
                wrap_y_q <= 1'b0;
              end
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.step_ready = step_ready;
  assign bus.pos_valid  = pos_valid_q;
  assign bus.pos_x      = pos_x_q;
  assign bus.pos_y      = pos_y_q;
  assign bus.wrap_x     = wrap_x_q;
  assign bus.wrap_y     = wrap_y_q;
  assign busy           = (state_q == ACTIVE);
  assign done           = done_q;
  assign count          = count_q;

endmodule

// File: tb/tb_raster_stepper.sv
// tb_raster_stepper: directed bench for raster_stepper. Three instances share
// the same stimulus: u_wrap (defaults), u_sat (WRAP=0) and u_small (a 4x3
// field, so a complete raster scan fits in a handful of cycles).
module tb_raster_stepper;

  localparam int W = 10;
  localparam int H = 11;

  logic         clock;
  logic         rst_n;
  logic         start;
  logic         stop;
  logic         mode;
  logic [W-1:0] origin_x;
  logic [H-1:0] origin_y;
  logic         step_valid;
  logic [W-1:0] step_dx;
  logic [H-1:0] step_dy;
  logic         pos_ready;

  logic         busy_a, done_a, busy_s, done_s, busy_m, done_m;
  logic [W+H-1:0] count_a, count_s, count_m;

  int errors = 0;
  int checks = 0;

  raster_stepper_if #(.WIDTH(W), .HEIGHT(H)) if_a ();
  raster_stepper_if #(.WIDTH(W), .HEIGHT(H)) if_s ();
  raster_stepper_if #(.WIDTH(W), .HEIGHT(H)) if_m ();

  assign if_a.step_valid = step_valid;
  assign if_a.step_dx    = step_dx;
  assign if_a.step_dy    = step_dy;
  assign if_a.pos_ready  = pos_ready;
  assign if_s.step_valid = step_valid;
  assign if_s.step_dx    = step_dx;
  assign if_s.step_dy    = step_dy;
  assign if_s.pos_ready  = pos_ready;
  assign if_m.step_valid = step_valid;
  assign if_m.step_dx    = step_dx;
  assign if_m.step_dy    = step_dy;
  assign if_m.pos_ready  = pos_ready;

  raster_stepper #(.WIDTH(W), .HEIGHT(H), .X_LIMIT(640), .Y_LIMIT(480), .WRAP(1)) u_wrap (
    .clock(clock), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .origin_x(origin_x), .origin_y(origin_y), .bus(if_a.slave),
    .busy(busy_a), .done(done_a), .count(count_a)
  );

  raster_stepper #(.WIDTH(W), .HEIGHT(H), .X_LIMIT(640), .Y_LIMIT(480), .WRAP(0)) u_sat (
    .clock(clock), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .origin_x(origin_x), .origin_y(origin_y), .bus(if_s.slave),
    .busy(busy_s), .done(done_s), .count(count_s)
  );

  raster_stepper #(.WIDTH(W), .HEIGHT(H), .X_LIMIT(4), .Y_LIMIT(3), .WRAP(1)) u_small (
    .clock(clock), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .origin_x(origin_x), .origin_y(origin_y), .bus(if_m.slave),
    .busy(busy_m), .done(done_m), .count(count_m)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0;
    origin_x = '0; origin_y = '0;
    step_valid = 1'b0; step_dx = '0; step_dy = '0; pos_ready = 1'b0;

    // Reset values
    #12;
    check("rst pos_x",      if_a.pos_x, 0);
    check("rst pos_y",      if_a.pos_y, 0);
    check("rst pos_valid",  if_a.pos_valid, 0);
    check("rst step_ready", if_a.step_ready, 0);
    check("rst wrap_x",     if_a.wrap_x, 0);
    check("rst wrap_y",     if_a.wrap_y, 0);
    check("rst busy",       busy_a, 0);
    check("rst done",       done_a, 0);
    check("rst count",      count_a, 0);
    rst_n = 1'b1;
    tick();

    // Step mode from (5,7), step (+3,-2)
    start = 1'b1; mode = 1'b0; origin_x = 10'd5; origin_y = 11'd7;
    tick();
    start = 1'b0;
    check("s1 busy",       busy_a, 1);
    check("s1 origin x",   if_a.pos_x, 5);
    check("s1 origin y",   if_a.pos_y, 7);
    check("s1 no valid",   if_a.pos_valid, 0);
    check("s1 step_ready", if_a.step_ready, 1);
    step_valid = 1'b1; step_dx = 10'd3; step_dy = 11'h7FE; pos_ready = 1'b1;
    tick();
    step_valid = 1'b0;
    check("s1 pos_x",     if_a.pos_x, 8);
    check("s1 pos_y",     if_a.pos_y, 5);
    check("s1 pos_valid", if_a.pos_valid, 1);
    check("s1 wrap_x",    if_a.wrap_x, 0);
    check("s1 wrap_y",    if_a.wrap_y, 0);
    check("s1 count0",    count_a, 0);
    tick();
    check("s1 count1",    count_a, 1);
    check("s1 drained",   if_a.pos_valid, 0);
    pulse_stop();
    check("s1 stopped",   busy_a, 0);

    // Wrap / saturate from (638,1), step (+5,-3)
    start = 1'b1; origin_x = 10'd638; origin_y = 11'd1;
    tick();
    start = 1'b0;
    step_valid = 1'b1; step_dx = 10'd5; step_dy = 11'h7FD;
    tick();
    check("wrap pos_x",  if_a.pos_x, 3);
    check("wrap pos_y",  if_a.pos_y, 478);
    check("wrap wrap_x", if_a.wrap_x, 1);
    check("wrap wrap_y", if_a.wrap_y, 1);
    check("sat pos_x",   if_s.pos_x, 639);
    check("sat pos_y",   if_s.pos_y, 0);
    check("sat wrap_x",  if_s.wrap_x, 1);
    check("sat wrap_y",  if_s.wrap_y, 1);
    // Back-to-back step (+1,+1): wrap flags are not sticky
    step_dx = 10'd1; step_dy = 11'd1;
    tick();
    check("b2b pos_x",     if_a.pos_x, 4);
    check("b2b pos_y",     if_a.pos_y, 479);
    check("b2b wrap_x",    if_a.wrap_x, 0);
    check("b2b wrap_y",    if_a.wrap_y, 0);
    check("b2b count",     count_a, 1);
    check("b2b sat x",     if_s.pos_x, 639);
    check("b2b sat y",     if_s.pos_y, 1);
    check("b2b sat wrapx", if_s.wrap_x, 1);
    check("b2b sat wrapy", if_s.wrap_y, 0);

    // Backpressure with the next step (-10,-479) held pending
    step_dx = 10'h3F6; step_dy = 11'h621; pos_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp step_ready", if_a.step_ready, 0);
      check("bp pos_valid",  if_a.pos_valid, 1);
      check("bp hold x",     if_a.pos_x, 4);
      check("bp hold y",     if_a.pos_y, 479);
    end
    pos_ready = 1'b1;
    #1;
    check("bp release ready", if_a.step_ready, 1);
    tick();
    step_valid = 1'b0;
    check("bp pos_x",   if_a.pos_x, 634);
    check("bp pos_y",   if_a.pos_y, 0);
    check("bp wrap_x",  if_a.wrap_x, 1);
    check("bp wrap_y",  if_a.wrap_y, 0);
    check("bp count",   count_a, 2);
    check("bp sat x",   if_s.pos_x, 629);
    check("bp sat y",   if_s.pos_y, 0);
    check("bp sat wx",  if_s.wrap_x, 0);
    check("bp sat wy",  if_s.wrap_y, 1);
    tick();
    check("bp count3",  count_a, 3);
    check("bp drained", if_a.pos_valid, 0);
    pulse_stop();

    // Raster from (0,0): full scan of the 4x3 instance, partial of the default one
    start = 1'b1; mode = 1'b1; origin_x = '0; origin_y = '0;
    tick();
    start = 1'b0;
    check("ras step_ready", if_a.step_ready, 0);
    for (int i = 0; i < 12; i++) begin
      check("ras small x",    if_m.pos_x, i % 4);
      check("ras small y",    if_m.pos_y, i / 4);
      check("ras small wx",   if_m.wrap_x, (i > 0 && i % 4 == 0) ? 1 : 0);
      check("ras small vld",  if_m.pos_valid, 1);
      check("ras small done", done_m, 0);
      check("ras big x",      if_a.pos_x, i);
      tick();
    end
    check("ras small done1", done_m, 1);
    check("ras small count", count_m, 12);
    check("ras small busy",  busy_m, 0);
    check("ras small vld0",  if_m.pos_valid, 0);
    tick();
    check("ras small done0", done_m, 0);
    repeat (626) tick();
    check("ras big x639",   if_a.pos_x, 639);
    check("ras big y0",     if_a.pos_y, 0);
    check("ras big count",  count_a, 639);
    tick();
    check("ras big x0",     if_a.pos_x, 0);
    check("ras big y1",     if_a.pos_y, 1);
    check("ras big wx",     if_a.wrap_x, 1);
    check("ras big count2", count_a, 640);
    pulse_stop();

    // Raster tail with clamped origin (637, 2047) -> (637, 479)
    start = 1'b1; origin_x = 10'd637; origin_y = 11'd2047;
    tick();
    start = 1'b0;
    check("tail clamp x", if_a.pos_x, 637);
    check("tail clamp y", if_a.pos_y, 479);
    tick();
    check("tail x638", if_a.pos_x, 638);
    tick();
    check("tail x639", if_a.pos_x, 639);
    check("tail busy", busy_a, 1);
    check("tail no done", done_a, 0);
    tick();
    check("tail done",  done_a, 1);
    check("tail count", count_a, 3);
    check("tail idle",  busy_a, 0);
    check("tail vld0",  if_a.pos_valid, 0);
    tick();
    check("tail done once", done_a, 0);

    // Abort after 10 raster transfers; stop wins over the concurrent transfer
    start = 1'b1; origin_x = '0; origin_y = '0;
    tick();
    start = 1'b0;
    repeat (10) tick();
    check("abort count10", count_a, 10);
    check("abort x10",     if_a.pos_x, 10);
    pulse_stop();
    check("abort idle",  busy_a, 0);
    check("abort vld0",  if_a.pos_valid, 0);
    check("abort done0", done_a, 0);
    check("abort count", count_a, 10);

    // Asynchronous reset mid-run
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("pre-reset x", if_a.pos_x, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst pos_x",     if_a.pos_x, 0);
    check("arst pos_y",     if_a.pos_y, 0);
    check("arst pos_valid", if_a.pos_valid, 0);
    check("arst busy",      busy_a, 0);
    check("arst count",     count_a, 0);
    check("arst wrap_x",    if_a.wrap_x, 0);
    check("arst done",      done_a, 0);
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
